guess_compare_display: RTL and testbench
========================================

// Module: guess_compare_display
// PURPOSE
//  Scoring stage of the up/down number-guessing game. On each guess strobe it
//  compares the player's number with the secret number and latches a verdict:
//  go UP (guess too low), go DOWN (too high) or CORRECT.
//  The verdict drives one 7-segment digit directly and sits between the input
//  handler and the board display pins.
// PARAMETERS
//  N_BITS          7  width of user_number / actual_number (unsigned)
//  SEG_ACTIVE_LOW  1  1: segment lit when bit=0 (common anode); 0: bits inverted
// PORTS
//  clk            in   1       system clock; all state updates on rising edge
//  reset          in   1       synchronous, active-low reset (0 = reset at clk edge)
//  guess_trigger  in   1       guess strobe, level; only its rising edge counts
//  user_number    in   N_BITS  player's guess, unsigned
//  actual_number  in   N_BITS  secret number, unsigned
//  seg_display    out  7       segments {g,f,e,d,c,b,a} = [6:0]
// BEHAVIOUR
//  - State: trig_q (1 bit, previous guess_trigger) and verdict (2 bits).
//  - verdict encoding: NONE=0, UP=1, DOWN=2, CORRECT=3.
//  - Reset (reset==0 at a clk edge): verdict<=NONE and trig_q<=0.
//    Reset has priority over a simultaneous trigger.
//  - Every non-reset edge: trig_q<=guess_trigger; rise = guess_trigger & ~trig_q.
//  - On an edge with rise=1, verdict is loaded from the inputs sampled at that edge:
//      user_number <  actual_number -> UP
//      user_number >  actual_number -> DOWN
//      user_number == actual_number -> CORRECT
//    Comparison is unsigned over the full N_BITS (0 vs 127 gives UP).
//  - Latency: seg_display shows the new verdict right after the sampling edge.
//    It is a combinational decode of the verdict register, with no input-to-output
//    combinational path.
//  - A trigger held high for many cycles is scored once. Another guess needs
//    trigger low for at least one edge.
//  - With no rise, the inputs may change freely; the verdict and display hold.
//  - Trigger high on the first edge after reset release counts as a rise
//    (trig_q was cleared).
//  - Reset asserted mid-game returns the display to NONE on the same edge.
//  - Segment patterns with SEG_ACTIVE_LOW=1 (bits [6:0]=gfedcba):
//      NONE    '-'  7'b0111111
//      UP      'U'  7'b1000001
//      DOWN    'd'  7'b0100001
//      CORRECT 'C'  7'b1000110
//    With SEG_ACTIVE_LOW=0 the output is the bitwise inverse.
//  - No X propagation: every decode branch has a default (NONE pattern).
// STRUCTURE
//  - Shared package guess_game_pkg:
//      verdict_t enum (NONE, UP, DOWN, CORRECT)
//      SEG_DASH, SEG_U, SEG_D, SEG_C constants (active-low form)
//      N_BITS default
//  - Sub-module seg7_verdict_enc: combinational verdict_t -> 7-bit pattern,
//    with the polarity parameter applied.
//  - Top level holds the edge detector, the comparator and the verdict register.
// TESTING
//  1. reset=0 for 10 cycles, trigger=0 -> seg_display=7'b0111111 throughout.
//  2. actual=42, user=42, one-cycle trigger pulse -> 7'b1000110 (C) one edge later.
//  3. actual=42, user=85, pulse -> 7'b0100001 (d); change user to 10 without
//     trigger -> still 7'b0100001.
//  4. actual=42, user=1, pulse -> 7'b1000001 (U).
//     Boundaries: user=0/actual=127 -> U; user=127/actual=0 -> d.
//  5. Trigger held high 5 cycles while user goes 1 -> 85 -> one verdict only (U).
//     Drop trigger and raise again -> d.
//  6. Verdict=C, then reset=0 on the same edge as a trigger rise -> 7'b0111111.
//     Release reset with trigger already high -> scored on the first edge.

Source files
------------

// File: rtl/guess_game_pkg.sv
// Shared types and constants for the number-guessing game.
// Holds the verdict encoding and active-low 7-segment glyphs.
package guess_game_pkg;

   localparam int N_BITS_DEF = 7;

   typedef enum logic [1:0] {
      NONE    = 2'd0,
      UP      = 2'd1,
      DOWN    = 2'd2,
      CORRECT = 2'd3
   } verdict_t;

   // Segment order {g,f,e,d,c,b,a}; a 0 bit lights the segment.
   localparam logic [6:0] SEG_DASH = 7'b0111111;
   localparam logic [6:0] SEG_U    = 7'b1000001;
   localparam logic [6:0] SEG_D    = 7'b0100001;
   localparam logic [6:0] SEG_C    = 7'b1000110;

endpackage

// File: rtl/guess_compare_display_enc.sv
// Verdict to 7-segment decoder with selectable polarity.
// Ports: verdict (in, verdict_t), seg (out, 7 bits gfedcba).
module seg7_verdict_enc
   import guess_game_pkg::*;
#(
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  verdict_t   verdict,
   output logic [6:0] seg
);

   logic [6:0] pat;

   always_comb begin
      pat = SEG_DASH;
      case (verdict)
         UP:      pat = SEG_U;
         DOWN:    pat = SEG_D;
         CORRECT: pat = SEG_C;
         default: pat = SEG_DASH;
      endcase
   end

   // Glyphs are stored active-low; invert for common-cathode boards.
   assign seg = SEG_ACTIVE_LOW ? pat : ~pat;

endmodule

// File: rtl/guess_compare_display.sv
// Scores a guess on the trigger's rising edge and shows the verdict.
// Ports: clk, reset (sync active-low), guess_trigger, user_number,
//        actual_number, seg_display (7 bits gfedcba).
module guess_compare_display
   import guess_game_pkg::*;
#(
   parameter int N_BITS         = N_BITS_DEF,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              guess_trigger,
   input  logic [N_BITS-1:0] user_number,
   input  logic [N_BITS-1:0] actual_number,
   output logic [6:0]        seg_display
);

   logic     trig_q;
   logic     rise;
   verdict_t verdict;
   verdict_t score;

   assign rise = guess_trigger & ~trig_q;

   always_comb begin
      score = CORRECT;
      if (user_number < actual_number)
         score = UP;
      else if (user_number > actual_number)
         score = DOWN;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         trig_q  <= 1'b0;
         verdict <= NONE;
      end else begin
         trig_q <= guess_trigger;
         if (rise)
            verdict <= score;
      end
   end

   // Display depends only on the registered verdict.
   seg7_verdict_enc #(
      .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
   ) u_enc (
      .verdict(verdict),
      .seg    (seg_display)
   );

endmodule

// File: tb/tb_guess_compare_display.sv
// Directed bench for guess_compare_display.
// Checks both display polarities against hand-computed glyphs.
module tb_guess_compare_display;

   localparam logic [6:0] P_DASH = 7'b0111111;
   localparam logic [6:0] P_U    = 7'b1000001;
   localparam logic [6:0] P_D    = 7'b0100001;
   localparam logic [6:0] P_C    = 7'b1000110;

   logic       clk = 1'b0;
   logic       reset;
   logic       guess_trigger;
   logic [6:0] user_number;
   logic [6:0] actual_number;
   logic [6:0] seg_lo;
   logic [6:0] seg_hi;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   guess_compare_display #(
      .N_BITS(7),
      .SEG_ACTIVE_LOW(1'b1)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .guess_trigger(guess_trigger),
      .user_number  (user_number),
      .actual_number(actual_number),
      .seg_display  (seg_lo)
   );

   guess_compare_display #(
      .N_BITS(7),
      .SEG_ACTIVE_LOW(1'b0)
   ) dut_inv (
      .clk          (clk),
      .reset        (reset),
      .guess_trigger(guess_trigger),
      .user_number  (user_number),
      .actual_number(actual_number),
      .seg_display  (seg_hi)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [6:0] exp);
      logic [6:0] exp_inv;
      exp_inv = ~exp;
      tests++;
      assert (seg_lo === exp) else begin
         failed++;
         $error("FAIL %s: seg_display=%b expected=%b", tag, seg_lo, exp);
      end
      tests++;
      assert (seg_hi === exp_inv) else begin
         failed++;
         $error("FAIL %s_inv: seg_display=%b expected=%b",
                tag, seg_hi, exp_inv);
      end
   endtask

   initial begin
      reset         = 1'b0;
      guess_trigger = 1'b0;
      user_number   = 7'd0;
      actual_number = 7'd0;

      // 1: held in reset
      for (int i = 0; i < 10; i++) begin
         tick();
         check("reset_hold", P_DASH);
      end
      reset = 1'b1;
      tick();
      check("reset_release", P_DASH);

      // 2: equal -> C
      actual_number = 7'd42;
      user_number   = 7'd42;
      guess_trigger = 1'b1;
      tick();
      check("eq_c", P_C);
      guess_trigger = 1'b0;
      tick();
      check("eq_c_hold", P_C);

      // 3: too high -> d, then inputs change without trigger
      user_number   = 7'd85;
      guess_trigger = 1'b1;
      tick();
      check("high_d", P_D);
      guess_trigger = 1'b0;
      user_number   = 7'd10;
      tick();
      check("no_trig_hold1", P_D);
      tick();
      check("no_trig_hold2", P_D);

      // 4: too low -> U, then full-range boundaries
      user_number   = 7'd1;
      guess_trigger = 1'b1;
      tick();
      check("low_u", P_U);
      guess_trigger = 1'b0;
      tick();
      user_number   = 7'd127;
      actual_number = 7'd0;
      guess_trigger = 1'b1;
      tick();
      check("bound_127_0", P_D);
      guess_trigger = 1'b0;
      tick();
      user_number   = 7'd0;
      actual_number = 7'd127;
      guess_trigger = 1'b1;
      tick();
      check("bound_0_127", P_U);
      guess_trigger = 1'b0;
      tick();

      // 5: held trigger scores once
      actual_number = 7'd42;
      user_number   = 7'd42;
      guess_trigger = 1'b1;
      tick();
      check("pre_hold_c", P_C);
      guess_trigger = 1'b0;
      tick();
      user_number   = 7'd1;
      guess_trigger = 1'b1;
      tick();
      check("hold_first_u", P_U);
      user_number = 7'd85;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("hold_once", P_U);
      end
      guess_trigger = 1'b0;
      tick();
      check("hold_drop", P_U);
      guess_trigger = 1'b1;
      tick();
      check("hold_rerise_d", P_D);
      guess_trigger = 1'b0;
      tick();

      // 6: reset beats a simultaneous rise; release with trigger high
      user_number   = 7'd42;
      guess_trigger = 1'b1;
      tick();
      check("pre_rst_c", P_C);
      guess_trigger = 1'b0;
      tick();
      reset         = 1'b0;
      guess_trigger = 1'b1;
      tick();
      check("rst_priority", P_DASH);
      reset = 1'b1;
      tick();
      check("rst_release_rise", P_C);
      user_number = 7'd3;
      tick();
      check("rst_release_held", P_C);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
